amt_param_recover: RTL and testbench

Parametrised architectural map table (AMT) for the retire stage. It accepts up to COMMIT_WIDTH retiring destination mappings per cycle and resolves same-destination conflicts inside the commit window. It returns each displaced physical register to the free list. On recovery, a sequencer walks the whole table RECOVER_WIDTH entries per cycle to rebuild the rename map table, with explicit busy and done signalling.

---
 rtl/amt_param_recover.sv | 154 +++++++++++++++
 tb/tb_amt_param_recover.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amt_param_recover.sv
`default_nettype none
// ============================================================================
// Module   : amt_param_recover
// Brief    : Retire-stage architectural map table with in-window conflict
//            resolution, tag release and a grouped recovery walk.
// Revision : 1.0 - initial release
// ============================================================================
module amt_param_recover #(
    parameter int COMMIT_WIDTH  = 4,
    parameter int NUM_LOG       = 32,
    parameter int LOG_W         = 5,
    parameter int PHYS_W        = 7,
    parameter int RECOVER_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [COMMIT_WIDTH-1:0]           commit_valid_i,
    input  logic [COMMIT_WIDTH*LOG_W-1:0]     commit_log_i,
    input  logic [COMMIT_WIDTH*PHYS_W-1:0]    commit_phys_i,
    input  logic                              recover_req_i,
    output logic [COMMIT_WIDTH-1:0]           released_valid_o,
    output logic [COMMIT_WIDTH*PHYS_W-1:0]    released_phys_o,
    output logic                              recover_valid_o,
    output logic [RECOVER_WIDTH*LOG_W-1:0]    recover_log_o,
    output logic [RECOVER_WIDTH*PHYS_W-1:0]   recover_phys_o,
    output logic                              recover_busy_o,
    output logic                              recover_done_o
);

    localparam logic [0:0]       S_IDLE     = 1'b0;
    localparam logic [0:0]       S_WALK     = 1'b1;
    localparam logic [LOG_W-1:0] C_LAST_CNT = LOG_W'(NUM_LOG - RECOVER_WIDTH);
    localparam logic [LOG_W-1:0] C_STEP     = LOG_W'(RECOVER_WIDTH);

    logic [PHYS_W-1:0]       r_table [NUM_LOG];
    logic [0:0]              r_state;
    logic [0:0]              w_state_next;
    logic [LOG_W-1:0]        r_cnt;
    logic [LOG_W-1:0]        w_cnt_next;
    logic [LOG_W-1:0]        w_log  [COMMIT_WIDTH];
    logic [PHYS_W-1:0]       w_phys [COMMIT_WIDTH];
    logic [LOG_W-1:0]        w_grp_idx [RECOVER_WIDTH];
    logic [COMMIT_WIDTH-1:0] w_super;
    logic [COMMIT_WIDTH-1:0] w_commit;
    logic [COMMIT_WIDTH-1:0] w_write;
    logic                    w_idle;
    logic                    w_last;

    generate
        for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_unpack
            assign w_log[k]  = commit_log_i[k*LOG_W +: LOG_W];
            assign w_phys[k] = commit_phys_i[k*PHYS_W +: PHYS_W];
        end
        for (genvar g = 0; g < RECOVER_WIDTH; g++) begin : g_grp_idx
            assign w_grp_idx[g] = r_cnt + LOG_W'(g);
        end
    endgenerate

    assign w_idle = (r_state == S_IDLE);
    assign w_last = (r_cnt == C_LAST_CNT);

    // A slot loses its write when any younger valid slot targets the same register.
    always_comb begin
        w_super = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            for (int j = k + 1; j < COMMIT_WIDTH; j++) begin
                if (commit_valid_i[j] && (w_log[j] == w_log[k])) begin
                    w_super[k] = 1'b1;
                end
            end
        end
    end

    assign w_commit = commit_valid_i & {COMMIT_WIDTH{w_idle}};
    assign w_write  = w_commit & ~w_super;

    always_comb begin
        released_valid_o = w_commit;
        released_phys_o  = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (w_commit[k]) begin
                released_phys_o[k*PHYS_W +: PHYS_W] = w_super[k] ? w_phys[k] : r_table[w_log[k]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LOG; i++) begin
                r_table[i] <= PHYS_W'(i);
            end
        end else begin
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (w_write[k]) begin
                    r_table[w_log[k]] <= w_phys[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (recover_req_i) begin
                    w_state_next = S_WALK;
                    w_cnt_next   = '0;
                end
            end
            S_WALK: begin
                if (w_last) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + C_STEP;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        recover_valid_o = 1'b0;
        recover_busy_o  = 1'b0;
        recover_done_o  = 1'b0;
        recover_log_o   = '0;
        recover_phys_o  = '0;
        if (r_state == S_WALK) begin
            recover_valid_o = 1'b1;
            recover_busy_o  = 1'b1;
            recover_done_o  = w_last;
            for (int g = 0; g < RECOVER_WIDTH; g++) begin
                recover_log_o[g*LOG_W +: LOG_W]    = w_grp_idx[g];
                recover_phys_o[g*PHYS_W +: PHYS_W] = r_table[w_grp_idx[g]];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_amt_param_recover.sv
`default_nettype none
// ============================================================================
// Module   : tb_amt_param_recover
// Brief    : Self-checking bench for amt_param_recover against a simple
//            array model of the architectural map.
// Revision : 1.0 - initial release
// ============================================================================
module tb_amt_param_recover;

    localparam int CW = 4;
    localparam int NL = 32;
    localparam int LW = 5;
    localparam int PW = 7;
    localparam int RW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [CW-1:0]     commit_valid_i;
    logic [CW*LW-1:0]  commit_log_i;
    logic [CW*PW-1:0]  commit_phys_i;
    logic              recover_req_i;
    logic [CW-1:0]     released_valid_o;
    logic [CW*PW-1:0]  released_phys_o;
    logic              recover_valid_o;
    logic [RW*LW-1:0]  recover_log_o;
    logic [RW*PW-1:0]  recover_phys_o;
    logic              recover_busy_o;
    logic              recover_done_o;

    amt_param_recover #(
        .COMMIT_WIDTH(CW), .NUM_LOG(NL), .LOG_W(LW), .PHYS_W(PW), .RECOVER_WIDTH(RW)
    ) dut (
        .clk(clk), .reset(reset),
        .commit_valid_i(commit_valid_i), .commit_log_i(commit_log_i),
        .commit_phys_i(commit_phys_i), .recover_req_i(recover_req_i),
        .released_valid_o(released_valid_o), .released_phys_o(released_phys_o),
        .recover_valid_o(recover_valid_o), .recover_log_o(recover_log_o),
        .recover_phys_o(recover_phys_o), .recover_busy_o(recover_busy_o),
        .recover_done_o(recover_done_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference map: plain array, later commits simply overwrite earlier ones.
    int              mtbl [NL];
    logic [CW-1:0]   exp_rv;
    logic [CW*PW-1:0] exp_rp;
    logic            pend_live;

    task automatic model_identity();
        for (int i = 0; i < NL; i++) mtbl[i] = i;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a commit bundle and derive the expected release from the model.
    task automatic drive_commit(input logic [CW-1:0] v, input logic [CW*LW-1:0] l,
                                input logic [CW*PW-1:0] p, input logic walking);
        commit_valid_i = v;
        commit_log_i   = l;
        commit_phys_i  = p;
        pend_live      = !walking;
        exp_rv = '0;
        exp_rp = '0;
        if (!walking) begin
            for (int k = 0; k < CW; k++) begin
                bit younger_same = 0;
                for (int j = k + 1; j < CW; j++)
                    if (v[j] && l[j*LW +: LW] == l[k*LW +: LW]) younger_same = 1;
                if (v[k]) begin
                    exp_rv[k] = 1'b1;
                    exp_rp[k*PW +: PW] = younger_same ? p[k*PW +: PW]
                                                      : PW'(mtbl[l[k*LW +: LW]]);
                end
            end
        end
    endtask

    task automatic tick_commit();
        tick();
        if (pend_live && !reset) begin
            for (int k = 0; k < CW; k++)
                if (commit_valid_i[k]) mtbl[commit_log_i[k*LW +: LW]] = int'(commit_phys_i[k*PW +: PW]);
        end
        if (reset) model_identity();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        recover_req_i = 1'b0;
        drive_commit('0, '0, '0, 1'b1);
        tick(); tick();
        reset = 1'b0;
        model_identity();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (released_valid_o !== '0 || released_phys_o !== '0 || recover_valid_o !== 1'b0 ||
            recover_busy_o !== 1'b0 || recover_done_o !== 1'b0 || recover_log_o !== '0 ||
            recover_phys_o !== '0)
            begin errors++; $display("FAIL reset_outputs rv=%h rp=%h valid=%b busy=%b done=%b want all 0",
                released_valid_o, released_phys_o, recover_valid_o, recover_busy_o, recover_done_o); end
    endtask

    task automatic test_basic();
        drive_commit(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {7'd0, 7'd0, 7'd0, 7'd40}, 1'b0);
        #1;
        checks++;
        if (released_valid_o !== 4'b0001 || released_phys_o !== {7'd0, 7'd0, 7'd0, 7'd3})
            begin errors++; $display("FAIL basic_first got v=%b p=%h want v=0001 p=%h",
                released_valid_o, released_phys_o, {7'd0, 7'd0, 7'd0, 7'd3}); end
        tick_commit();
        drive_commit(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {7'd0, 7'd0, 7'd0, 7'd41}, 1'b0);
        #1;
        checks++;
        if (released_phys_o !== {7'd0, 7'd0, 7'd0, 7'd40} || released_phys_o !== exp_rp)
            begin errors++; $display("FAIL basic_second got p=%h want p=%h", released_phys_o, exp_rp); end
        tick_commit();
    endtask

    task automatic test_same_dest();
        drive_commit(4'b0111, {5'd5, 5'd5, 5'd5, 5'd5}, {7'd0, 7'd52, 7'd51, 7'd50}, 1'b0);
        #1;
        checks++;
        if (released_valid_o !== 4'b0111 || released_phys_o !== {7'd0, 7'd5, 7'd51, 7'd50})
            begin errors++; $display("FAIL same_dest got v=%b p=%h want v=0111 p=%h",
                released_valid_o, released_phys_o, {7'd0, 7'd5, 7'd51, 7'd50}); end
        tick_commit();
        drive_commit(4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, {7'd0, 7'd0, 7'd0, 7'd53}, 1'b0);
        #1;
        checks++;
        if (released_phys_o[PW-1:0] !== 7'd52)
            begin errors++; $display("FAIL same_dest_table5 got %0d want 52", released_phys_o[PW-1:0]); end
        tick_commit();
    endtask

    task automatic test_mixed();
        drive_commit(4'b1111, {5'd2, 5'd1, 5'd2, 5'd1}, {7'd63, 7'd62, 7'd61, 7'd60}, 1'b0);
        #1;
        checks++;
        if (released_valid_o !== 4'b1111 || released_phys_o !== {7'd2, 7'd1, 7'd61, 7'd60})
            begin errors++; $display("FAIL mixed got v=%b p=%h want v=1111 p=%h",
                released_valid_o, released_phys_o, {7'd2, 7'd1, 7'd61, 7'd60}); end
        tick_commit();
        drive_commit(4'b0011, {5'd0, 5'd0, 5'd2, 5'd1}, {7'd0, 7'd0, 7'd2, 7'd1}, 1'b0);
        #1;
        checks++;
        if (released_phys_o !== {7'd0, 7'd0, 7'd63, 7'd62})
            begin errors++; $display("FAIL mixed_table got p=%h want p=%h",
                released_phys_o, {7'd0, 7'd0, 7'd63, 7'd62}); end
        tick_commit();
    endtask

    task automatic test_recovery();
        do_reset();
        drive_commit(4'b0001, {5'd0, 5'd0, 5'd0, 5'd7}, {7'd0, 7'd0, 7'd0, 7'd90}, 1'b0);
        tick_commit();
        drive_commit('0, '0, '0, 1'b0);
        recover_req_i = 1'b1;
        tick_commit();
        recover_req_i = 1'b0;
        for (int c = 0; c < NL / RW; c++) begin
            checks++;
            if (recover_valid_o !== 1'b1 || recover_busy_o !== 1'b1 || recover_done_o !== (c == NL / RW - 1))
                begin errors++; $display("FAIL walk_flags grp=%0d valid=%b busy=%b done=%b want 1 1 %0d",
                    c, recover_valid_o, recover_busy_o, recover_done_o, (c == NL / RW - 1)); end
            for (int g = 0; g < RW; g++) begin
                int idx = c * RW + g;
                checks++;
                if (recover_log_o[g*LW +: LW] !== LW'(idx) || recover_phys_o[g*PW +: PW] !== PW'(mtbl[idx]))
                    begin errors++; $display("FAIL walk_entry grp=%0d g=%0d log=%0d phys=%0d want log=%0d phys=%0d",
                        c, g, recover_log_o[g*LW +: LW], recover_phys_o[g*PW +: PW], idx, mtbl[idx]); end
            end
            if (c == 1) begin
                checks++;
                if (recover_phys_o !== {7'd90, 7'd6, 7'd5, 7'd4})
                    begin errors++; $display("FAIL walk_group1 got %h want %h",
                        recover_phys_o, {7'd90, 7'd6, 7'd5, 7'd4}); end
            end
            tick_commit();
        end
        checks++;
        if (recover_busy_o !== 1'b0 || recover_valid_o !== 1'b0 || recover_done_o !== 1'b0)
            begin errors++; $display("FAIL walk_end busy=%b valid=%b done=%b want 0",
                recover_busy_o, recover_valid_o, recover_done_o); end
    endtask

    task automatic test_walk_commit();
        int cycles;
        drive_commit('0, '0, '0, 1'b0);
        recover_req_i = 1'b1;
        tick_commit();
        recover_req_i = 1'b0;
        cycles = 0;
        while (recover_busy_o === 1'b1 && cycles < 20) begin
            drive_commit(4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, {7'd0, 7'd0, 7'd0, 7'd70}, 1'b1);
            recover_req_i = (cycles == 3);
            #1;
            checks++;
            if (released_valid_o !== 4'b0000 || released_phys_o !== '0)
                begin errors++; $display("FAIL walk_commit_release cyc=%0d v=%b p=%h want 0",
                    cycles, released_valid_o, released_phys_o); end
            tick_commit();
            cycles++;
        end
        recover_req_i = 1'b0;
        checks++;
        if (cycles !== NL / RW)
            begin errors++; $display("FAIL walk_length got %0d cycles want %0d", cycles, NL / RW); end
        drive_commit(4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, {7'd0, 7'd0, 7'd0, 7'd71}, 1'b0);
        #1;
        checks++;
        if (released_valid_o !== 4'b0001 || released_phys_o[PW-1:0] !== 7'd0)
            begin errors++; $display("FAIL walk_commit_table0 v=%b p=%0d want v=0001 p=0",
                released_valid_o, released_phys_o[PW-1:0]); end
        tick_commit();
    endtask

    task automatic test_random_commit();
        logic [CW-1:0]    v;
        logic [CW*LW-1:0] l;
        logic [CW*PW-1:0] p;
        for (int n = 0; n < 200; n++) begin
            v = CW'($urandom);
            for (int k = 0; k < CW; k++) begin
                l[k*LW +: LW] = (n % 2 == 0) ? LW'($urandom_range(0, 3)) : LW'($urandom_range(0, NL - 1));
                p[k*PW +: PW] = PW'($urandom);
            end
            drive_commit(v, l, p, 1'b0);
            #1;
            checks++;
            if (released_valid_o !== exp_rv || released_phys_o !== exp_rp)
                begin errors++; $display("FAIL random_commit n=%0d v=%b p=%h want v=%b p=%h",
                    n, released_valid_o, released_phys_o, exp_rv, exp_rp); end
            tick_commit();
        end
    endtask

    task automatic test_reset_mid_walk();
        drive_commit('0, '0, '0, 1'b0);
        recover_req_i = 1'b1;
        tick_commit();
        recover_req_i = 1'b0;
        tick_commit(); tick_commit(); tick_commit();
        checks++;
        if (recover_busy_o !== 1'b1 || recover_log_o[LW-1:0] !== 5'd12)
            begin errors++; $display("FAIL midwalk_position busy=%b log0=%0d want 1 12",
                recover_busy_o, recover_log_o[LW-1:0]); end
        reset = 1'b1;
        tick_commit();
        reset = 1'b0;
        checks++;
        if (recover_busy_o !== 1'b0 || recover_valid_o !== 1'b0 || recover_done_o !== 1'b0)
            begin errors++; $display("FAIL midwalk_reset busy=%b valid=%b done=%b want 0",
                recover_busy_o, recover_valid_o, recover_done_o); end
        recover_req_i = 1'b1;
        tick_commit();
        recover_req_i = 1'b0;
        for (int c = 0; c < NL / RW; c++) begin
            for (int g = 0; g < RW; g++) begin
                int idx = c * RW + g;
                checks++;
                if (recover_log_o[g*LW +: LW] !== LW'(idx) || recover_phys_o[g*PW +: PW] !== PW'(idx))
                    begin errors++; $display("FAIL identity_walk idx=%0d log=%0d phys=%0d want %0d",
                        idx, recover_log_o[g*LW +: LW], recover_phys_o[g*PW +: PW], idx); end
            end
            tick_commit();
        end
    endtask

    initial begin
        model_identity();
        test_reset();
        test_basic();
        test_same_dest();
        test_mixed();
        test_recovery();
        test_walk_commit();
        test_random_commit();
        test_reset_mid_walk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
